shake_share_arb: RTL and testbench
==================================

Name: shake_share_arb

Overview:
- Shares one shake128_top instance among NUM_CH requesters, e.g. Ed25519 signer plus a key-derivation or DRBG client.
- Each channel's request is buffered in its own slot; one slot is granted at a time, round-robin.
- The granted request is issued to the SHAKE core; the digest is returned with a per-channel done pulse.
- Sits between the client cores and the SHAKE core, as the parametrised successor of the single-client Ed25519/SHAKE pairing.

Parameters:
NUM_CH, 2, number of client channels (2..8)
DIN_W, 1024, SHAKE input data width in bits
DOUT_W, 512, SHAKE output digest width in bits
LEN_W, 7, byte-length field width
MODE_W, 3, SHAKE mode/type field width
TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with SHAKE_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
req_start  in  NUM_CH  per-channel request pulse
req_mode  in  NUM_CH*MODE_W  per-channel mode, channel i at [i*MODE_W +: MODE_W]
req_din  in  NUM_CH*DIN_W  per-channel message data
req_len  in  NUM_CH*LEN_W  per-channel byte length
ch_busy  out  NUM_CH  slot i occupied (pending or in service)
rsp_done  out  NUM_CH  one-cycle completion pulse for channel i
rsp_dout  out  DOUT_W  digest of the most recently completed request
shake_start  out  1  one-cycle start to SHAKE core
shake_type  out  MODE_W  mode to SHAKE core
shake_din  out  DIN_W  data to SHAKE core
shake_len  out  LEN_W  byte length to SHAKE core
shake_dout  in  DOUT_W  digest from SHAKE core
shake_done  in  1  SHAKE completion pulse
shake_busy  in  1  SHAKE core busy

Behaviour:
- Reset: all outputs 0; pend[] = 0; rr_ptr = 0; FSM = IDLE. This applies mid-operation too; no rsp_done is issued for an aborted job.
- Capture:
  - req_start[i] sampled while pend[i]=0 latches mode/din/len into slot i, and pend[i] <= 1.
  - req_start[i] while pend[i]=1 is ignored; the slot contents are unchanged.
  - ch_busy = pend.
- FSM IDLE:
  - If any pend is set and shake_busy=0, grant g = the first pending channel scanning from rr_ptr upward, wrapping modulo NUM_CH.
  - Drive the shake_type/din/len registers from slot g; go to ISSUE.
  - If shake_busy=1, stay in IDLE.
- FSM ISSUE: shake_start=1 for exactly this cycle; go to WAIT. shake_type/din/len stay stable from ISSUE through WAIT.
- FSM WAIT:
  - On shake_done, register rsp_dout <= shake_dout; go to RESP.
  - shake_done in any other state is ignored.
- FSM RESP:
  - rsp_done[g]=1 for one cycle; pend[g] <= 0; rr_ptr <= (g+1) mod NUM_CH; go to IDLE.
  - req_start[g] in the RESP cycle is accepted (clear and recapture on the same edge; capture wins).
- Latency:
  - req_start at cycle t into an idle arbiter gives shake_start at t+2.
  - shake_done at cycle d gives rsp_done at d+1.
  - rsp_dout is valid from d+1 and held until the next completion.
- Fairness: a pending channel is served within NUM_CH-1 other jobs.

Optional Feature:
- Macro: SHAKE_ARB_TIMEOUT_EN.
- With the macro defined:
  - Adds output err (1 bit, reset 0) and a cycle counter running in WAIT.
  - If shake_done has not arrived after TIMEOUT_CYC cycles, err <= 1 (sticky until rst) and rsp_done[g] is pulsed with rsp_dout = 0.
  - pend[g] is cleared, rr_ptr advances, and the FSM returns to IDLE.
- Without the macro: no err port; WAIT waits indefinitely.

Test Plan:
- Single request: ch0 start, len=32, mode=1, din=0xABC -> shake_start at t+2 with those values; model done after 24 cycles -> rsp_done=01 one cycle later, rsp_dout = model digest.
- Simultaneous: ch0 and ch1 start in the same cycle -> ch0 served first, then ch1; rr_ptr then favours ch0; two distinct rsp_done pulses, never overlapping.
- Repeat start: ch1 start again while ch_busy[1]=1 with din=0x5 -> ignored; served data equals the first din.
- Back-to-back: ch0 start in its own RESP cycle -> accepted, second shake_start issued, ch_busy[0] stays 1.
- Reset mid-WAIT: assert rst -> all outputs 0, pend cleared, no rsp_done; a late shake_done after reset is ignored.
- With SHAKE_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: withhold shake_done -> err=1 after 16 WAIT cycles, rsp_done pulses with rsp_dout=0, and the next channel is then served.

Source files
------------

// File: rtl/shake_share_arb_if.sv
// Bundle between the client channels, the arbiter and the shared SHAKE core.
// slave  : arbiter side (takes requests, drives the core's command inputs).
// master : environment side (clients plus the SHAKE core).
interface shake_share_arb_if #(
    parameter int NUM_CH = 2,
    parameter int DIN_W  = 1024,
    parameter int DOUT_W = 512,
    parameter int LEN_W  = 7,
    parameter int MODE_W = 3
);
    logic [NUM_CH-1:0]        req_start;
    logic [NUM_CH*MODE_W-1:0] req_mode;
    logic [NUM_CH*DIN_W-1:0]  req_din;
    logic [NUM_CH*LEN_W-1:0]  req_len;
    logic [NUM_CH-1:0]        ch_busy;
    logic [NUM_CH-1:0]        rsp_done;
    logic [DOUT_W-1:0]        rsp_dout;
    logic                     shake_start;
    logic [MODE_W-1:0]        shake_type;
    logic [DIN_W-1:0]         shake_din;
    logic [LEN_W-1:0]         shake_len;
    logic [DOUT_W-1:0]        shake_dout;
    logic                     shake_done;
    logic                     shake_busy;

    modport slave (
        input  req_start, req_mode, req_din, req_len,
        input  shake_dout, shake_done, shake_busy,
        output ch_busy, rsp_done, rsp_dout,
        output shake_start, shake_type, shake_din, shake_len
    );

    modport master (
        output req_start, req_mode, req_din, req_len,
        output shake_dout, shake_done, shake_busy,
        input  ch_busy, rsp_done, rsp_dout,
        input  shake_start, shake_type, shake_din, shake_len
    );
endinterface

// File: rtl/shake_share_arb.sv
// Round-robin sharing of one SHAKE core among NUM_CH client channels.
// Each channel owns a request slot; one granted slot at a time is issued to
// the core and its digest is returned with a per-channel done pulse.
// Optional build macro SHAKE_ARB_TIMEOUT_EN adds a WAIT watchdog and the
// sticky err output.
module shake_share_arb #(
    parameter int NUM_CH      = 2,
    parameter int DIN_W       = 1024,
    parameter int DOUT_W      = 512,
    parameter int LEN_W       = 7,
    parameter int MODE_W      = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,
    shake_share_arb_if.slave   bus
`ifdef SHAKE_ARB_TIMEOUT_EN
    ,
    output logic               err
`endif
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   pend;
    logic [NUM_CH-1:0]   grant_oh;
    logic [PTR_W-1:0]    rr_q, grant_q, pick;
    logic                pick_vld;
    logic                timeout;
    logic                shake_start_c;
    logic [NUM_CH-1:0]   rsp_done_c;
    int                  idx;

    logic [MODE_W-1:0]   slot_mode [NUM_CH];
    logic [DIN_W-1:0]    slot_din  [NUM_CH];
    logic [LEN_W-1:0]    slot_len  [NUM_CH];

    logic [MODE_W-1:0]   shake_type_q;
    logic [DIN_W-1:0]    shake_din_q;
    logic [LEN_W-1:0]    shake_len_q;
    logic [DOUT_W-1:0]   rsp_dout_q;

    // Per-channel request slots. A slot is released in its RESP cycle; a new
    // request arriving on that same edge is taken (capture beats clear).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [PTR_W-1:0] CH = PTR_W'(gi);
            logic              pend_q;
            logic              clr;
            logic [MODE_W-1:0] mode_q;
            logic [DIN_W-1:0]  din_q;
            logic [LEN_W-1:0]  len_q;

            assign clr = (state_q == S_RESP) && (grant_q == CH);

            // Slot capture / release.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pend_q <= 1'b0;
                    mode_q <= '0;
                    din_q  <= '0;
                    len_q  <= '0;
                end else if (bus.req_start[gi] && (!pend_q || clr)) begin
                    pend_q <= 1'b1;
                    mode_q <= bus.req_mode[gi*MODE_W +: MODE_W];
                    din_q  <= bus.req_din[gi*DIN_W +: DIN_W];
                    len_q  <= bus.req_len[gi*LEN_W +: LEN_W];
                end else if (clr) begin
                    pend_q <= 1'b0;
                end
            end

            assign pend[gi]      = pend_q;
            assign grant_oh[gi]  = (grant_q == CH);
            assign slot_mode[gi] = mode_q;
            assign slot_din[gi]  = din_q;
            assign slot_len[gi]  = len_q;
        end
    endgenerate

    // First pending channel at or after rr_q, wrapping; scanned from the far
    // end so the nearest candidate is the last (winning) assignment.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (pend[PTR_W'(idx)]) begin
                pick     = PTR_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_vld && !bus.shake_busy) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (bus.shake_done || timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: start pulse in ISSUE, per-channel done pulse in RESP.
    always_comb begin
        shake_start_c = 1'b0;
        rsp_done_c    = '0;
        case (state_q)
            S_ISSUE: shake_start_c = 1'b1;
            S_RESP:  rsp_done_c    = grant_oh;
            default: ;
        endcase
    end

    // Grant, core command registers, digest capture and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q      <= '0;
            rr_q         <= '0;
            shake_type_q <= '0;
            shake_din_q  <= '0;
            shake_len_q  <= '0;
            rsp_dout_q   <= '0;
        end else begin
            if (state_q == S_IDLE && state_d == S_ISSUE) begin
                grant_q      <= pick;
                shake_type_q <= slot_mode[pick];
                shake_din_q  <= slot_din[pick];
                shake_len_q  <= slot_len[pick];
            end
            if (state_q == S_WAIT) begin
                if (bus.shake_done) rsp_dout_q <= bus.shake_dout;
                else if (timeout)   rsp_dout_q <= '0;
            end
            if (state_q == S_RESP) begin
                rr_q <= (grant_q == PTR_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

`ifdef SHAKE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] wait_cnt_q;

    // Cycles spent in WAIT for the current job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    wait_cnt_q <= '0;
        else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
        else                        wait_cnt_q <= '0;
    end

    assign timeout = (state_q == S_WAIT) && !bus.shake_done &&
                     (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err <= 1'b0;
        else if (timeout) err <= 1'b1;
    end
`else
    // No watchdog in this build: constant 0 (TIMEOUT_CYC is always positive).
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    assign bus.ch_busy     = pend;
    assign bus.rsp_done    = rsp_done_c;
    assign bus.rsp_dout    = rsp_dout_q;
    assign bus.shake_start = shake_start_c;
    assign bus.shake_type  = shake_type_q;
    assign bus.shake_din   = shake_din_q;
    assign bus.shake_len   = shake_len_q;
endmodule

// File: tb/tb_shake_share_arb.sv
// Directed bench for shake_share_arb with a small behavioural SHAKE core model.
module tb_shake_share_arb;
    localparam int NUM_CH = 2;
    localparam int DIN_W  = 256;
    localparam int DOUT_W = 128;
    localparam int LEN_W  = 7;
    localparam int MODE_W = 3;
    localparam int TO_CYC = 16;
    localparam int REPL   = DOUT_W / 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   model_cnt = 0;
    int   model_lat = 24;
    bit   model_en = 1'b1;
    bit   busy_force = 1'b0;
    logic [DOUT_W-1:0] model_dig = '0;

    shake_share_arb_if #(.NUM_CH(NUM_CH), .DIN_W(DIN_W), .DOUT_W(DOUT_W),
                         .LEN_W(LEN_W), .MODE_W(MODE_W)) bus();
`ifdef SHAKE_ARB_TIMEOUT_EN
    logic err;
`endif

    shake_share_arb #(.NUM_CH(NUM_CH), .DIN_W(DIN_W), .DOUT_W(DOUT_W),
                      .LEN_W(LEN_W), .MODE_W(MODE_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SHAKE_ARB_TIMEOUT_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Reference digest used by the core model and by the expected values.
    function automatic logic [DOUT_W-1:0] dig(input logic [DIN_W-1:0] d,
                                              input logic [MODE_W-1:0] m,
                                              input logic [LEN_W-1:0] l);
        dig = d[DOUT_W-1:0] ^ (DOUT_W'(l) << 8) ^ (DOUT_W'(m) << 20) ^ {REPL{32'hA5A5_1234}};
    endfunction

    // One clock; outputs are sampled 1 time unit after the edge. The core model
    // answers a shake_start with shake_done model_lat cycles later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.shake_done = 1'b0;
        if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) begin
                bus.shake_done = 1'b1;
                bus.shake_dout = model_dig;
            end
        end
        if (bus.shake_start && model_en) begin
            model_cnt = model_lat;
            model_dig = dig(bus.shake_din, bus.shake_type, bus.shake_len);
        end
        bus.shake_busy = busy_force | (model_cnt > 0);
    endtask

    task automatic set_req(input int ch, input logic [MODE_W-1:0] m,
                           input logic [LEN_W-1:0] l, input logic [DIN_W-1:0] d);
        bus.req_start = bus.req_start | (NUM_CH'(1) << ch);
        bus.req_mode  = (bus.req_mode & ~((NUM_CH*MODE_W)'({MODE_W{1'b1}}) << (ch*MODE_W)))
                        | ((NUM_CH*MODE_W)'(m) << (ch*MODE_W));
        bus.req_len   = (bus.req_len & ~((NUM_CH*LEN_W)'({LEN_W{1'b1}}) << (ch*LEN_W)))
                        | ((NUM_CH*LEN_W)'(l) << (ch*LEN_W));
        bus.req_din   = (bus.req_din & ~((NUM_CH*DIN_W)'({DIN_W{1'b1}}) << (ch*DIN_W)))
                        | ((NUM_CH*DIN_W)'(d) << (ch*DIN_W));
    endtask

    // Drop the start pulses and scramble the data so slots must hold their copy.
    task automatic clr_req();
        bus.req_start = '0;
        bus.req_din   = '1;
        bus.req_mode  = '1;
        bus.req_len   = '1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.ch_busy !== 2'b00) begin errors++; $display("FAIL reset_ch_busy: got %b want 00", bus.ch_busy); end
        checks++; if (bus.rsp_done !== 2'b00) begin errors++; $display("FAIL reset_rsp_done: got %b want 00", bus.rsp_done); end
        checks++; if (bus.shake_start !== 1'b0) begin errors++; $display("FAIL reset_shake_start: got %b want 0", bus.shake_start); end
        checks++; if (bus.shake_type !== '0 || bus.shake_len !== '0) begin errors++; $display("FAIL reset_type_len: got %h/%h want 0/0", bus.shake_type, bus.shake_len); end
        checks++; if (bus.shake_din !== '0) begin errors++; $display("FAIL reset_shake_din: got %h want 0", bus.shake_din); end
        checks++; if (bus.rsp_dout !== '0) begin errors++; $display("FAIL reset_rsp_dout: got %h want 0", bus.rsp_dout); end
`ifdef SHAKE_ARB_TIMEOUT_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
`endif
        rst = 1'b0;
        tick();
        tick();
        checks++; if (bus.shake_start !== 1'b0 || bus.ch_busy !== 2'b00) begin errors++; $display("FAIL reset_idle: got start=%b busy=%b want 0/00", bus.shake_start, bus.ch_busy); end
    endtask

    task automatic test_single();
        int n;
        model_lat = 24;
        set_req(0, 3'd1, 7'd32, DIN_W'(12'hABC));
        tick();
        clr_req();
        checks++; if (bus.ch_busy !== 2'b01) begin errors++; $display("FAIL single_busy: got %b want 01", bus.ch_busy); end
        checks++; if (bus.shake_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b want 0", bus.shake_start); end
        tick();
        checks++; if (bus.shake_start !== 1'b1) begin errors++; $display("FAIL single_start_t2: got %b want 1", bus.shake_start); end
        checks++; if (bus.shake_type !== 3'd1 || bus.shake_len !== 7'd32) begin errors++; $display("FAIL single_type_len: got %0d/%0d want 1/32", bus.shake_type, bus.shake_len); end
        checks++; if (bus.shake_din !== DIN_W'(12'hABC)) begin errors++; $display("FAIL single_din: got %h want abc", bus.shake_din); end
        tick();
        checks++; if (bus.shake_start !== 1'b0 || bus.shake_din !== DIN_W'(12'hABC)) begin errors++; $display("FAIL single_start_pulse: got start=%b din=%h want 0/abc", bus.shake_start, bus.shake_din); end
        n = 0;
        while (bus.rsp_done === 2'b00 && n < 60) begin tick(); n++; end
        checks++; if (n !== 24) begin errors++; $display("FAIL single_latency: got %0d want 24 cycles after start+1", n); end
        checks++; if (bus.rsp_done !== 2'b01) begin errors++; $display("FAIL single_rsp_done: got %b want 01", bus.rsp_done); end
        checks++; if (bus.rsp_dout !== dig(DIN_W'(12'hABC), 3'd1, 7'd32)) begin errors++; $display("FAIL single_dout: got %h want %h", bus.rsp_dout, dig(DIN_W'(12'hABC), 3'd1, 7'd32)); end
        $display("txn single ch_mask=%b dout=%h cyc=%0d", bus.rsp_done, bus.rsp_dout, cyc);
        tick();
        checks++; if (bus.rsp_done !== 2'b00 || bus.ch_busy !== 2'b00) begin errors++; $display("FAIL single_after: got done=%b busy=%b want 00/00", bus.rsp_done, bus.ch_busy); end
        checks++; if (bus.rsp_dout !== dig(DIN_W'(12'hABC), 3'd1, 7'd32)) begin errors++; $display("FAIL single_dout_hold: got %h", bus.rsp_dout); end
    endtask

    // Both channels request together; first_ch is the channel rr_ptr favours.
    task automatic test_simultaneous(input int first_ch);
        int n_st, n_done, overlap;
        logic [DIN_W-1:0]  st0, st1, exp_d0, exp_d1;
        logic [DOUT_W-1:0] dout0, dout1, exp_o0, exp_o1;
        logic [1:0]        done0, done1, exp_m0, exp_m1;
        n_st = 0; n_done = 0; overlap = 0;
        st0 = '0; st1 = '0; dout0 = '0; dout1 = '0; done0 = '0; done1 = '0;
        model_lat = 6;
        set_req(0, 3'd2, 7'd10, DIN_W'(12'h100));
        set_req(1, 3'd3, 7'd20, DIN_W'(12'h200));
        tick();
        clr_req();
        for (int k = 0; k < 80 && n_done < 2; k++) begin
            tick();
            if (bus.shake_start === 1'b1) begin
                if (n_st == 0) st0 = bus.shake_din;
                else if (n_st == 1) st1 = bus.shake_din;
                n_st++;
            end
            if (bus.rsp_done !== 2'b00) begin
                if (bus.rsp_done === 2'b11) overlap++;
                if (n_done == 0) begin done0 = bus.rsp_done; dout0 = bus.rsp_dout; end
                else begin done1 = bus.rsp_done; dout1 = bus.rsp_dout; end
                $display("txn simultaneous ch_mask=%b dout=%h cyc=%0d", bus.rsp_done, bus.rsp_dout, cyc);
                n_done++;
            end
        end
        exp_m0 = (first_ch == 0) ? 2'b01 : 2'b10;
        exp_m1 = (first_ch == 0) ? 2'b10 : 2'b01;
        exp_d0 = (first_ch == 0) ? DIN_W'(12'h100) : DIN_W'(12'h200);
        exp_d1 = (first_ch == 0) ? DIN_W'(12'h200) : DIN_W'(12'h100);
        exp_o0 = (first_ch == 0) ? dig(DIN_W'(12'h100), 3'd2, 7'd10) : dig(DIN_W'(12'h200), 3'd3, 7'd20);
        exp_o1 = (first_ch == 0) ? dig(DIN_W'(12'h200), 3'd3, 7'd20) : dig(DIN_W'(12'h100), 3'd2, 7'd10);
        checks++; if (n_done !== 2) begin errors++; $display("FAIL sim_count: got %0d completions want 2", n_done); end
        checks++; if (done0 !== exp_m0 || done1 !== exp_m1) begin errors++; $display("FAIL sim_order: got %b,%b want %b,%b", done0, done1, exp_m0, exp_m1); end
        checks++; if (st0 !== exp_d0 || st1 !== exp_d1) begin errors++; $display("FAIL sim_issue_din: got %h,%h want %h,%h", st0[15:0], st1[15:0], exp_d0[15:0], exp_d1[15:0]); end
        checks++; if (dout0 !== exp_o0 || dout1 !== exp_o1) begin errors++; $display("FAIL sim_dout: got %h,%h want %h,%h", dout0, dout1, exp_o0, exp_o1); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL sim_overlap: got %0d overlapping pulses want 0", overlap); end
        tick();
        checks++; if (bus.ch_busy !== 2'b00) begin errors++; $display("FAIL sim_busy_end: got %b want 00", bus.ch_busy); end
    endtask

    task automatic test_repeat_start();
        int n;
        model_lat = 8;
        set_req(1, 3'd5, 7'd40, DIN_W'(12'h111));
        tick();
        clr_req();
        checks++; if (bus.ch_busy !== 2'b10) begin errors++; $display("FAIL repeat_busy: got %b want 10", bus.ch_busy); end
        set_req(1, 3'd6, 7'd41, DIN_W'(4'h5));
        tick();
        clr_req();
        n = 0;
        while (bus.shake_start !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (bus.shake_din !== DIN_W'(12'h111) || bus.shake_type !== 3'd5 || bus.shake_len !== 7'd40) begin errors++; $display("FAIL repeat_issue: got din=%h type=%0d len=%0d want 111/5/40", bus.shake_din[15:0], bus.shake_type, bus.shake_len); end
        n = 0;
        while (bus.rsp_done === 2'b00 && n < 40) begin tick(); n++; end
        checks++; if (bus.rsp_done !== 2'b10) begin errors++; $display("FAIL repeat_done: got %b want 10", bus.rsp_done); end
        checks++; if (bus.rsp_dout !== dig(DIN_W'(12'h111), 3'd5, 7'd40)) begin errors++; $display("FAIL repeat_dout: got %h want %h", bus.rsp_dout, dig(DIN_W'(12'h111), 3'd5, 7'd40)); end
        $display("txn repeat ch_mask=%b dout=%h cyc=%0d", bus.rsp_done, bus.rsp_dout, cyc);
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        model_lat = 4;
        set_req(0, 3'd2, 7'd16, DIN_W'(12'h333));
        tick();
        clr_req();
        n = 0;
        while (bus.rsp_done === 2'b00 && n < 30) begin tick(); n++; end
        checks++; if (bus.rsp_done !== 2'b01 || bus.rsp_dout !== dig(DIN_W'(12'h333), 3'd2, 7'd16)) begin errors++; $display("FAIL b2b_first: got done=%b dout=%h", bus.rsp_done, bus.rsp_dout); end
        $display("txn b2b_first ch_mask=%b dout=%h cyc=%0d", bus.rsp_done, bus.rsp_dout, cyc);
        set_req(0, 3'd4, 7'd17, DIN_W'(12'h777));
        tick();
        clr_req();
        checks++; if (bus.ch_busy !== 2'b01 || bus.rsp_done !== 2'b00) begin errors++; $display("FAIL b2b_recapture: got busy=%b done=%b want 01/00", bus.ch_busy, bus.rsp_done); end
        tick();
        checks++; if (bus.shake_start !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", bus.shake_start); end
        checks++; if (bus.shake_din !== DIN_W'(12'h777) || bus.shake_type !== 3'd4 || bus.shake_len !== 7'd17) begin errors++; $display("FAIL b2b_issue: got din=%h type=%0d len=%0d want 777/4/17", bus.shake_din[15:0], bus.shake_type, bus.shake_len); end
        n = 0;
        while (bus.rsp_done === 2'b00 && n < 30) begin tick(); n++; end
        checks++; if (bus.rsp_done !== 2'b01 || bus.rsp_dout !== dig(DIN_W'(12'h777), 3'd4, 7'd17)) begin errors++; $display("FAIL b2b_second: got done=%b dout=%h", bus.rsp_done, bus.rsp_dout); end
        $display("txn b2b_second ch_mask=%b dout=%h cyc=%0d", bus.rsp_done, bus.rsp_dout, cyc);
        tick();
    endtask

    task automatic test_busy_hold();
        int n, starts;
        busy_force = 1'b1;
        bus.shake_busy = 1'b1;
        set_req(0, 3'd1, 7'd8, DIN_W'(12'h444));
        tick();
        clr_req();
        starts = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.shake_start === 1'b1) starts++;
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL busy_hold_start: got %0d starts want 0", starts); end
        checks++; if (bus.ch_busy !== 2'b01) begin errors++; $display("FAIL busy_hold_pend: got %b want 01", bus.ch_busy); end
        busy_force = 1'b0;
        bus.shake_busy = 1'b0;
        tick();
        checks++; if (bus.shake_start !== 1'b1 || bus.shake_din !== DIN_W'(12'h444)) begin errors++; $display("FAIL busy_release: got start=%b din=%h want 1/444", bus.shake_start, bus.shake_din[15:0]); end
        n = 0;
        while (bus.rsp_done === 2'b00 && n < 30) begin tick(); n++; end
        checks++; if (bus.rsp_done !== 2'b01 || bus.rsp_dout !== dig(DIN_W'(12'h444), 3'd1, 7'd8)) begin errors++; $display("FAIL busy_done: got done=%b dout=%h", bus.rsp_done, bus.rsp_dout); end
        $display("txn busy_hold ch_mask=%b dout=%h cyc=%0d", bus.rsp_done, bus.rsp_dout, cyc);
        tick();
    endtask

`ifdef SHAKE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        model_en = 1'b0;
        set_req(0, 3'd1, 7'd1, DIN_W'(12'h5A5));
        set_req(1, 3'd2, 7'd2, DIN_W'(12'h6B6));
        tick();
        clr_req();
        n = 0;
        while (bus.shake_start !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (bus.shake_din !== DIN_W'(12'h6B6)) begin errors++; $display("FAIL to_first_grant: got %h want 6b6", bus.shake_din[15:0]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b want 0", err); end
        n = 0;
        while (bus.rsp_done === 2'b00 && n < 40) begin tick(); n++; end
        checks++; if (n !== 17) begin errors++; $display("FAIL to_latency: got %0d want 17 cycles after start", n); end
        checks++; if (bus.rsp_done !== 2'b10 || bus.rsp_dout !== '0) begin errors++; $display("FAIL to_response: got done=%b dout=%h want 10/0", bus.rsp_done, bus.rsp_dout); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
        $display("txn timeout ch_mask=%b dout=%h cyc=%0d", bus.rsp_done, bus.rsp_dout, cyc);
        model_en = 1'b1;
        model_lat = 5;
        n = 0;
        while (bus.shake_start !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (bus.shake_din !== DIN_W'(12'h5A5)) begin errors++; $display("FAIL to_next_grant: got %h want 5a5", bus.shake_din[15:0]); end
        n = 0;
        while (bus.rsp_done === 2'b00 && n < 30) begin tick(); n++; end
        checks++; if (bus.rsp_done !== 2'b01 || bus.rsp_dout !== dig(DIN_W'(12'h5A5), 3'd1, 7'd1)) begin errors++; $display("FAIL to_next_done: got done=%b dout=%h", bus.rsp_done, bus.rsp_dout); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", err); end
        $display("txn after_timeout ch_mask=%b dout=%h cyc=%0d", bus.rsp_done, bus.rsp_dout, cyc);
        tick();
    endtask
`endif

    task automatic test_reset_mid_wait();
        int n, bad;
        model_en = 1'b1;
        model_lat = 12;
        set_req(1, 3'd3, 7'd30, DIN_W'(12'h999));
        tick();
        clr_req();
        n = 0;
        while (bus.shake_start !== 1'b1 && n < 10) begin tick(); n++; end
        tick(); tick(); tick();
        rst = 1'b1;
        #2;
        checks++; if (bus.ch_busy !== 2'b00 || bus.rsp_done !== 2'b00) begin errors++; $display("FAIL midrst_busy_done: got %b/%b want 00/00", bus.ch_busy, bus.rsp_done); end
        checks++; if (bus.shake_din !== '0 || bus.shake_type !== '0 || bus.shake_len !== '0) begin errors++; $display("FAIL midrst_cmd: got din=%h type=%0d len=%0d want 0", bus.shake_din[15:0], bus.shake_type, bus.shake_len); end
        checks++; if (bus.rsp_dout !== '0) begin errors++; $display("FAIL midrst_dout: got %h want 0", bus.rsp_dout); end
`ifdef SHAKE_ARB_TIMEOUT_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err); end
`endif
        tick();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.rsp_done !== 2'b00) bad++;
            if (bus.shake_start !== 1'b0) bad++;
            if (bus.ch_busy !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_late_done: got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        bus.req_start  = '0;
        bus.req_mode   = '0;
        bus.req_din    = '0;
        bus.req_len    = '0;
        bus.shake_dout = '0;
        bus.shake_done = 1'b0;
        bus.shake_busy = 1'b0;
        test_reset();
        test_single();
        test_simultaneous(1);
        test_repeat_start();
        test_back_to_back();
        test_busy_hold();
`ifdef SHAKE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        test_simultaneous(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test want finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
